rf_wr_arb: RTL and testbench
============================

RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 Parameter DEPTH, default 2: pending-result buffer entries, legal 2..4.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive full-and-blocked cycles before stall_req asserts.
REQ-003 clk  in  1  clock; the design is synchronous to its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wb_reg_write  in  1  pipeline WB write request; always granted the same cycle.
REQ-006 wb_waddr  in  5  pipeline WB destination register.
REQ-007 wb_wd  in  32  pipeline WB write data.
REQ-008 md_valid  in  1  multi-cycle unit result valid.
REQ-009 md_waddr  in  5  multi-cycle result destination.
REQ-010 md_wd  in  32  multi-cycle result data.
REQ-011 md_ready  out  1  buffer can accept a result; transfer occurs when md_valid && md_ready.
REQ-012 id_rs  in  5  ID-stage source register 1.
REQ-013 id_rt  in  5  ID-stage source register 2.
REQ-014 id_pend_hit  out  1  id_rs or id_rt (nonzero) matches a valid pending entry; ID must stall.
REQ-015 stall_req  out  1  request that the pipeline insert WB bubbles so the buffer drains.
REQ-016 rf_we  out  1  register-file write enable.
REQ-017 rf_waddr  out  5  register-file write address.
REQ-018 rf_wd  out  32  register-file write data.

Function
REQ-019 A WB write is "active" when wb_reg_write=1 and wb_waddr!=0.
REQ-020 When WB is active, rf_we=1 and rf_waddr/rf_wd equal wb_waddr/wb_wd combinationally, with zero latency.
REQ-021 When WB is not active and the buffer is non-empty, the head entry drives rf_waddr/rf_wd, rf_we=1, and the head pops at the clock edge.
REQ-022 When neither condition holds, rf_we=0 and rf_waddr/rf_wd are 0.
REQ-023 md_ready is 1 when the registered occupancy is less than DEPTH; a pop in the same cycle does not raise md_ready.
REQ-024 An accepted result with md_waddr=0 is consumed but not enqueued.
REQ-025 An accepted result is written no earlier than the cycle after acceptance; there is no bypass from md to rf.
REQ-026 Entries drain in strict FIFO order.
REQ-027 Simultaneous push and pop on a non-full buffer leaves occupancy unchanged and preserves order.
REQ-028 An active WB write whose wb_waddr matches valid pending entries invalidates those entries at that edge, so the younger write wins.
REQ-029 Invalidated entries are skipped and never drive rf_we.
REQ-030 If md pushes in the same cycle with an address equal to the active wb_waddr, the new entry is kept, because the md result is younger.
REQ-031 id_pend_hit is combinational over valid entries only, excludes register 0, and excludes the head entry being popped this cycle.
REQ-032 The starve counter increments each cycle the buffer is full and WB is active, resets to 0 otherwise, and saturates at STARVE_LIMIT.
REQ-033 stall_req is registered, asserts when the counter reaches STARVE_LIMIT, and deasserts the cycle after the buffer is no longer full.
REQ-034 Arbitration state: IDLE (empty), PEND (non-empty, not starved), STARVE (stall_req=1).
REQ-035 State transitions: IDLE->PEND on push; PEND->IDLE on last pop or invalidate; PEND->STARVE on counter=STARVE_LIMIT; STARVE->PEND when no longer full.

Reset
REQ-036 While rst=1: rf_we=0, md_ready=0, stall_req=0, id_pend_hit=0, buffer emptied, all valid bits cleared, starve counter=0, state=IDLE.
REQ-037 Reset mid-operation discards pending entries without writing them.
REQ-038 md_ready rises the first cycle after rst deasserts.

Structure
REQ-039 Shared package rf_arb_pkg holds: DEPTH and STARVE_LIMIT defaults, wr_req_t struct {waddr[4:0], wd[31:0]}, and the state enum.
REQ-040 One sub-module, rf_wr_fifo, provides the per-entry valid/invalidate buffer with address-compare outputs.
REQ-041 The arbiter mux, starve counter and FSM reside in rf_wr_arb.

Verification
REQ-042 Scenario: md push (r5, 0x11) with WB idle -> next cycle rf_we=1, rf_waddr=5, rf_wd=0x11; buffer empty after.
REQ-043 Scenario: WB (r3, 0xAA) active while entry (r7, 0x22) is pending -> rf_waddr=3 that cycle; r7 written the first WB-idle cycle.
REQ-044 Scenario: pending (r9, 0x1), then WB writes r9=0x2 -> r9 entry never written; id_pend_hit with id_rs=9 drops after the edge.
REQ-045 Scenario: fill 2 entries with WB active for 4 cycles -> stall_req=1 on the 5th cycle; md_ready=0 throughout; stall_req clears after one drain.
REQ-046 Scenario: md push to r0 -> accepted, no write, id_pend_hit=0 for id_rs=0.
REQ-047 Scenario: rst asserted with 2 entries pending -> no rf_we; md_ready=0 during rst and 1 the cycle after.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter: defaults,
// the pending-write record and the arbitration state encoding.
package rf_arb_pkg;

  localparam int DEPTH_DEFAULT        = 2;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [REG_DW-1:0] wd;
  } wr_req_t;

  // IDLE: nothing pending; PEND: results waiting; STARVE: stall requested.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_STARVE = 2'd2
  } arb_state_t;

  // A write to register 0 is architecturally a no-op.
  function automatic logic wr_active(input logic we, input logic [REG_AW-1:0] addr);
    return we && (addr != '0);
  endfunction

endpackage

// File: rtl/rf_wr_arb_if.sv
// Bundle of the arbiter's pipeline-side signals. The master side is the
// pipeline (WB stage, multi-cycle unit, ID stage); the slave side is the
// arbiter that owns the register-file write port.
interface rf_wr_arb_if;
  import rf_arb_pkg::*;

  // WB stage write request
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_waddr;
  logic [REG_DW-1:0] wb_wd;

  // Multi-cycle unit result handshake
  logic              md_valid;
  logic [REG_AW-1:0] md_waddr;
  logic [REG_DW-1:0] md_wd;
  logic              md_ready;

  // ID-stage hazard lookup
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_pend_hit;

  // Pipeline back-pressure
  logic              stall_req;

  // Register-file write port
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [REG_DW-1:0] rf_wd;

  modport master (
    output wb_reg_write, wb_waddr, wb_wd,
    output md_valid, md_waddr, md_wd,
    output id_rs, id_rt,
    input  md_ready, id_pend_hit, stall_req,
    input  rf_we, rf_waddr, rf_wd
  );

  modport slave (
    input  wb_reg_write, wb_waddr, wb_wd,
    input  md_valid, md_waddr, md_wd,
    input  id_rs, id_rt,
    output md_ready, id_pend_hit, stall_req,
    output rf_we, rf_waddr, rf_wd
  );

endinterface

// File: rtl/rf_wr_fifo.sv
// Pending-result buffer. Entries are kept compacted toward slot 0, so slot 0
// is always the oldest live entry. Each edge the buffer drops the popped head
// and any entry invalidated by a younger WB write to the same register, closes
// the gaps while preserving age order, then appends the pushed entry.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  wr_req_t           push_req_i,
  input  logic              pop_i,
  input  logic              inv_i,
  input  logic [REG_AW-1:0] inv_addr_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  output wr_req_t           head_o,
  output logic              head_vld_o,
  output logic [CW-1:0]     count_o,
  output logic [CW-1:0]     count_nxt_o,
  output logic              src_hit_o
);

  wr_req_t          ent_q [DEPTH];
  wr_req_t          ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [DEPTH-1:0] keep;

  // Decide which live entries survive this edge (not popped, not invalidated).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = vld_q[i]
              && !(pop_i && (i == 0))
              && !(inv_i && (ent_q[i].waddr == inv_addr_i));
    end
  end

  // Compact surviving entries in age order, then append the new result.
  always_comb begin
    int slot;
    // NOTE: blocking assignments here, because later loop iterations must see the updated slot index.
    slot  = 0;
    vld_d = '0;
    for (int j = 0; j < DEPTH; j++) begin
      ent_d[j] = ent_q[j];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == slot) begin
            ent_d[j] = ent_q[i];
            vld_d[j] = 1'b1;
          end
        end
        slot = slot + 1;
      end
    end
    if (push_i) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j == slot) begin
          ent_d[j] = push_req_i;
          vld_d[j] = 1'b1;
        end
      end
    end
    count_d = CW'(slot) + CW'(push_i);
  end

  // Source-operand lookup over live entries, ignoring the head leaving this cycle.
  always_comb begin
    src_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !(pop_i && (i == 0))) begin
        if (((rs_i != '0) && (ent_q[i].waddr == rs_i)) ||
            ((rt_i != '0) && (ent_q[i].waddr == rt_i))) begin
          src_hit_o = 1'b1;
        end
      end
    end
  end

  // Valid bits and occupancy; reset discards everything pending.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all registered state so every flop updates from pre-edge values.
    if (rst) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; the valid bits alone decide whether a slot means anything.
    ent_q <= ent_d;
  end

  assign head_o      = ent_q[0];
  assign head_vld_o  = vld_q[0];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter. The WB stage always owns the port when it
// writes a nonzero register; results from the multi-cycle unit wait in a small
// buffer and use the port on WB-idle cycles. If WB keeps the port busy while
// the buffer is full, the arbiter asks the pipeline for bubbles.
module rf_wr_arb
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  rf_wr_arb_if.slave   bus
);

  localparam int              CW         = $clog2(DEPTH + 1);
  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

  logic          wb_active;
  logic          full;
  logic          md_ready_w;
  logic          push;
  logic          pop;
  logic          inv;
  wr_req_t       md_req;
  wr_req_t       head;
  logic          head_vld;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          src_hit;

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  arb_state_t    state_q;
  arb_state_t    state_d;

  assign wb_active  = wr_active(bus.wb_reg_write, bus.wb_waddr);
  assign full       = (count == FULL_CNT);
  // Readiness follows registered occupancy only; a same-cycle pop does not help.
  assign md_ready_w = !rst && (count < FULL_CNT);
  // Results for register 0 are accepted and dropped.
  assign push       = md_ready_w && bus.md_valid && (bus.md_waddr != '0);
  assign pop        = !rst && !wb_active && head_vld;
  // A WB write is younger than anything pending for the same register.
  assign inv        = !rst && wb_active;
  assign md_req     = '{waddr: bus.md_waddr, wd: bus.md_wd};

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_req_i  (md_req),
    .pop_i       (pop),
    .inv_i       (inv),
    .inv_addr_i  (bus.wb_waddr),
    .rs_i        (bus.id_rs),
    .rt_i        (bus.id_rt),
    .head_o      (head),
    .head_vld_o  (head_vld),
    .count_o     (count),
    .count_nxt_o (count_nxt),
    .src_hit_o   (src_hit)
  );

  // Write-port mux: WB first, then the buffer head, otherwise idle zeros.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wd    = '0;
    if (!rst) begin
      if (wb_active) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_waddr;
        bus.rf_wd    = bus.wb_wd;
      end else if (head_vld) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = head.waddr;
        bus.rf_wd    = head.wd;
      end
    end
  end

  // Starvation count: consecutive cycles the buffer is full while WB holds the port.
  always_comb begin
    starve_d = '0;
    if (full && wb_active) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
    end
  end

  // Arbitration state transitions, evaluated on next-cycle occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (count_nxt != '0) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (count_nxt == '0) begin
          state_d = ST_IDLE;
        end else if ((starve_d == STARVE_MAX) && (count_nxt == FULL_CNT)) begin
          state_d = ST_STARVE;
        end
      end
      ST_STARVE: begin
        if (count_nxt != FULL_CNT) begin
          state_d = (count_nxt == '0) ? ST_IDLE : ST_PEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign bus.md_ready    = md_ready_w;
  assign bus.id_pend_hit = !rst && src_hit;
  assign bus.stall_req   = !rst && (state_q == ST_STARVE);

endmodule

// File: tb/tb_rf_wr_arb.sv
// Bench for rf_wr_arb: a directed vector table, two hand-written multi-cycle
// sequences (starvation and reset with pending entries), then random traffic
// compared against a queue-based reference model.
module tb_rf_wr_arb;
  import rf_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wr_arb_if bus ();

  rf_wr_arb #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wd;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_hit;
    logic        e_stall;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: pending writes in age order plus starvation tracking.
  wr_req_t mq[$];
  int      m_starve = 0;
  bit      m_stall  = 1'b0;

  vec_t tab[$];

  function automatic vec_t mk(input int r, we, wa, wd, mv, ma, md, rs, rt,
                              input int ewe, ea, ed, erdy, ehit, est);
    vec_t v;
    v.rst = 1'(r);       v.wb_we = 1'(we);    v.wb_addr = 5'(wa);  v.wb_wd = 32'(wd);
    v.md_valid = 1'(mv); v.md_addr = 5'(ma);  v.md_wd = 32'(md);
    v.rs = 5'(rs);       v.rt = 5'(rt);
    v.e_we = 1'(ewe);    v.e_addr = 5'(ea);   v.e_wd = 32'(ed);
    v.e_rdy = 1'(erdy);  v.e_hit = 1'(ehit);  v.e_stall = 1'(est);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Expected outputs for the current inputs, from the behavioural rules.
  function automatic vec_t model_expect(input vec_t v);
    vec_t e = v;
    bit   act = v.wb_we && (v.wb_addr != 0);
    int   first;
    e.e_we = 0; e.e_addr = 0; e.e_wd = 0; e.e_rdy = 0; e.e_hit = 0; e.e_stall = 0;
    if (!v.rst) begin
      e.e_rdy   = (mq.size() < DEPTH);
      e.e_stall = m_stall;
      if (act) begin
        e.e_we = 1; e.e_addr = v.wb_addr; e.e_wd = v.wb_wd;
      end else if (mq.size() > 0) begin
        e.e_we = 1; e.e_addr = mq[0].waddr; e.e_wd = mq[0].wd;
      end
      first = (!act && mq.size() > 0) ? 1 : 0;
      for (int i = first; i < mq.size(); i++) begin
        if ((v.rs != 0 && mq[i].waddr == v.rs) || (v.rt != 0 && mq[i].waddr == v.rt))
          e.e_hit = 1;
      end
    end
    return e;
  endfunction

  // Advance the model across one clock edge.
  task automatic model_update(input vec_t v);
    bit      act = v.wb_we && (v.wb_addr != 0);
    bit      was_full = (mq.size() == DEPTH);
    bit      rdy = (mq.size() < DEPTH);
    wr_req_t kept[$];
    if (v.rst) begin
      mq.delete(); m_starve = 0; m_stall = 0;
      return;
    end
    if (!act && mq.size() > 0) void'(mq.pop_front());
    if (act) begin
      foreach (mq[i]) if (mq[i].waddr != v.wb_addr) kept.push_back(mq[i]);
      mq = kept;
    end
    if (v.md_valid && rdy && v.md_addr != 0)
      mq.push_back(wr_req_t'{waddr: v.md_addr, wd: v.md_wd});
    m_starve = (was_full && act) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
    m_stall  = (m_starve == LIMIT) && (mq.size() == DEPTH);
  endtask

  task automatic apply(input vec_t v);
    rst              = v.rst;
    bus.wb_reg_write = v.wb_we;
    bus.wb_waddr     = v.wb_addr;
    bus.wb_wd        = v.wb_wd;
    bus.md_valid     = v.md_valid;
    bus.md_waddr     = v.md_addr;
    bus.md_wd        = v.md_wd;
    bus.id_rs        = v.rs;
    bus.id_rt        = v.rt;
  endtask

  // One cycle: drive, compare mid-cycle, clock, advance the model.
  task automatic run_cycle(input vec_t v, input bit use_tab, input string tag);
    vec_t e;
    apply(v);
    @(negedge clk);
    e = use_tab ? v : model_expect(v);
    check({tag, " rf_we"},       bus.rf_we,       e.e_we);
    check({tag, " rf_waddr"},    bus.rf_waddr,    e.e_addr);
    check({tag, " rf_wd"},       bus.rf_wd,       e.e_wd);
    check({tag, " md_ready"},    bus.md_ready,    e.e_rdy);
    check({tag, " id_pend_hit"}, bus.id_pend_hit, e.e_hit);
    check({tag, " stall_req"},   bus.stall_req,   e.e_stall);
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  initial begin
    //                rst we wa  wd    mv ma  md    rs  rt   ewe ea  ed    rdy hit st
    tab.push_back(mk(1, 1, 3,  'hAA, 1, 5,  'h11, 5,  0,   0,  0,  0,    0,  0,  0));
    tab.push_back(mk(1, 0, 0,  0,    0, 0,  0,    0,  0,   0,  0,  0,    0,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    0,  0,   0,  0,  0,    1,  0,  0));
    // md push r5, written the next WB-idle cycle
    tab.push_back(mk(0, 0, 0,  0,    1, 5,  'h11, 5,  0,   0,  0,  0,    1,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    5,  0,   1,  5,  'h11, 1,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    0,  0,   0,  0,  0,    1,  0,  0));
    // WB wins over pending r7
    tab.push_back(mk(0, 0, 0,  0,    1, 7,  'h22, 0,  0,   0,  0,  0,    1,  0,  0));
    tab.push_back(mk(0, 1, 3,  'hAA, 0, 0,  0,    7,  0,   1,  3,  'hAA, 1,  1,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    0,  7,   1,  7,  'h22, 1,  0,  0));
    // younger WB to r9 kills the pending r9
    tab.push_back(mk(0, 0, 0,  0,    1, 9,  'h1,  9,  0,   0,  0,  0,    1,  0,  0));
    tab.push_back(mk(0, 1, 9,  'h2,  0, 0,  0,    9,  0,   1,  9,  'h2,  1,  1,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    9,  0,   0,  0,  0,    1,  0,  0));
    // md push to the register WB is writing survives
    tab.push_back(mk(0, 1, 4,  'h33, 1, 4,  'h44, 4,  0,   1,  4,  'h33, 1,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    4,  0,   1,  4,  'h44, 1,  0,  0));
    // result for r0 is consumed, never written
    tab.push_back(mk(0, 0, 0,  0,    1, 0,  'h55, 0,  0,   0,  0,  0,    1,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    0,  0,   0,  0,  0,    1,  0,  0));
    // WB to r0 is not active, so the buffer drains
    tab.push_back(mk(0, 0, 0,  0,    1, 6,  'h66, 0,  0,   0,  0,  0,    1,  0,  0));
    tab.push_back(mk(0, 1, 0,  'h99, 0, 0,  0,    0,  0,   1,  6,  'h66, 1,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    0,  0,   0,  0,  0,    1,  0,  0));
    // fill, back-pressure, FIFO order
    tab.push_back(mk(0, 1, 1,  'h10, 1, 10, 'hA0, 0,  0,   1,  1,  'h10, 1,  0,  0));
    tab.push_back(mk(0, 1, 2,  'h20, 1, 11, 'hB0, 11, 10,  1,  2,  'h20, 1,  1,  0));
    tab.push_back(mk(0, 0, 0,  0,    1, 12, 'hC0, 11, 0,   1,  10, 'hA0, 0,  1,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    10, 0,   1,  11, 'hB0, 1,  0,  0));
    // simultaneous push and pop
    tab.push_back(mk(0, 0, 0,  0,    1, 13, 'hD0, 0,  0,   0,  0,  0,    1,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    1, 14, 'hE0, 14, 0,   1,  13, 'hD0, 1,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    14, 0,   1,  14, 'hE0, 1,  0,  0));
    tab.push_back(mk(0, 0, 0,  0,    0, 0,  0,    0,  0,   0,  0,  0,    1,  0,  0));

    foreach (tab[k]) run_cycle(tab[k], 1'b1, $sformatf("tab[%0d]", k));

    // Starvation: two entries pending, WB busy four cycles, then one drain.
    run_cycle(mk(0, 1, 20, 'h200, 1, 21, 'h210, 0,  0,   1, 20, 'h200, 1, 0, 0), 1'b1, "stv fill0");
    run_cycle(mk(0, 1, 22, 'h220, 1, 23, 'h230, 21, 0,   1, 22, 'h220, 1, 1, 0), 1'b1, "stv fill1");
    for (int k = 0; k < 4; k++)
      run_cycle(mk(0, 1, 24 + k, 'h240 + k, 1, 28, 'h280, 23, 0,
                   1, 24 + k, 'h240 + k, 0, 1, 0), 1'b1, $sformatf("stv busy%0d", k));
    run_cycle(mk(0, 0, 0,  0,     1, 28, 'h280, 21, 23,  1, 21, 'h210, 0, 1, 1), 1'b1, "stv stall");
    run_cycle(mk(0, 0, 0,  0,     0, 0,  0,     23, 0,   1, 23, 'h230, 1, 0, 0), 1'b1, "stv clear");
    run_cycle(mk(0, 0, 0,  0,     0, 0,  0,     0,  0,   0, 0,  0,     1, 0, 0), 1'b1, "stv empty");

    // Reset with two entries pending: nothing is written afterwards.
    run_cycle(mk(0, 1, 16, 'h160, 1, 17, 'h170, 0,  0,   1, 16, 'h160, 1, 0, 0), 1'b1, "rst fill0");
    run_cycle(mk(0, 1, 18, 'h180, 1, 19, 'h190, 17, 0,   1, 18, 'h180, 1, 1, 0), 1'b1, "rst fill1");
    run_cycle(mk(1, 0, 0,  0,     1, 20, 'h1,   17, 0,   0, 0,  0,     0, 0, 0), 1'b1, "rst hold0");
    run_cycle(mk(1, 0, 0,  0,     1, 20, 'h1,   17, 0,   0, 0,  0,     0, 0, 0), 1'b1, "rst hold1");
    run_cycle(mk(0, 0, 0,  0,     0, 0,  0,     17, 19,  0, 0,  0,     1, 0, 0), 1'b1, "rst after");
    run_cycle(mk(0, 0, 0,  0,     0, 0,  0,     0,  0,   0, 0,  0,     1, 0, 0), 1'b1, "rst idle");

    // Random traffic over a small register set so address collisions are common.
    for (int n = 0; n < 600; n++) begin
      vec_t v;
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rst      = ($urandom_range(0, 99) < 2);
      v.wb_we    = ($urandom_range(0, 99) < 65);
      v.wb_addr  = 5'($urandom_range(0, 7));
      v.wb_wd    = $urandom();
      v.md_valid = 1'($urandom_range(0, 1));
      v.md_addr  = 5'($urandom_range(0, 7));
      v.md_wd    = $urandom();
      v.rs       = 5'($urandom_range(0, 7));
      v.rt       = 5'($urandom_range(0, 7));
      run_cycle(v, 1'b0, $sformatf("rnd[%0d]", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
